// File: rtl/fsm_pkg.sv
// Types and constants shared by the serial front end and the Mealy FSMs it feeds.
package fsm_pkg;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    // Idle input level the FSMs are documented to expect between words.
    localparam logic SER_IDLE_BIT_DEFAULT = 1'b0;

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry word buffer between the valid/ready input and the shifter.
module ser_hold_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load,
    input  logic             take,
    output logic [WIDTH-1:0] hold_data,
    output logic             hold_valid
);

    logic [WIDTH-1:0] hold_data_q, hold_data_d;
    logic             hold_valid_q, hold_valid_d;

    // load and take never coincide: the producer may only load while empty.
    always_comb begin
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        if (load) begin
            hold_data_d  = load_data;
            hold_valid_d = 1'b1;
        end else if (take) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    assign hold_data  = hold_data_q;
    assign hold_valid = hold_valid_q;

endmodule

// File: rtl/fsm_bit_serializer.sv
// Parallel-to-serial front end: buffers one word and streams it one bit per
// clock onto x, back-to-back words without gaps, IDLE_BIT in between.
module fsm_bit_serializer
    import fsm_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic        IDLE_BIT  = SER_IDLE_BIT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_active,
    output logic             word_start,
    output logic             word_done
);

    localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    if (WIDTH < 2) begin : g_width_check
        $error("fsm_bit_serializer: WIDTH must be at least 2");
    end

    logic [WIDTH-1:0] hold_data;
    logic             hold_valid;
    logic             accept;
    logic             take;

    assign in_ready = !hold_valid && !reset;
    assign accept   = in_valid && in_ready;

    ser_hold_buf #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk       (clk),
        .reset     (reset),
        .load_data (in_data),
        .load      (accept),
        .take      (take),
        .hold_data (hold_data),
        .hold_valid(hold_valid)
    );

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             x_q, x_d;
    logic             x_active_q, x_active_d;
    logic             word_start_q, word_start_d;
    logic             word_done_q, word_done_d;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        take    = 1'b0;
        case (state_q)
            SER_IDLE: begin
                if (hold_valid) begin
                    shreg_d = hold_data;
                    cnt_d   = '0;
                    take    = 1'b1;
                    state_d = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                if (cnt_q == LAST) begin
                    if (hold_valid) begin
                        shreg_d = hold_data;
                        cnt_d   = '0;
                        take    = 1'b1;
                    end else begin
                        cnt_d   = '0;
                        state_d = SER_IDLE;
                    end
                end else begin
                    shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                        : {1'b0, shreg_q[WIDTH-1:1]};
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = SER_IDLE;
        endcase

        // Outputs are decoded from next-state values so they come straight off flops
        // while showing the same cycle-by-cycle behaviour as a decode of the state.
        x_d          = IDLE_BIT;
        x_active_d   = 1'b0;
        word_start_d = 1'b0;
        word_done_d  = 1'b0;
        if (state_d == SER_SHIFT) begin
            x_d          = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
            x_active_d   = 1'b1;
            word_start_d = (cnt_d == '0);
            word_done_d  = (cnt_d == LAST);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= SER_IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            x_q          <= IDLE_BIT;
            x_active_q   <= 1'b0;
            word_start_q <= 1'b0;
            word_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            x_q          <= x_d;
            x_active_q   <= x_active_d;
            word_start_q <= word_start_d;
            word_done_q  <= word_done_d;
        end
    end

    assign x          = x_q;
    assign x_active   = x_active_q;
    assign word_start = word_start_q;
    assign word_done  = word_done_q;

endmodule

// File: tb/tb_fsm_bit_serializer.sv
// Directed bench for fsm_bit_serializer: MSB-first, LSB-first and IDLE_BIT=1
// instances share one stimulus stream; observed as {x, x_active, start, done, in_ready}.
module tb_fsm_bit_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;

    logic rdy_m, x_m, xa_m, ws_m, wd_m;
    logic rdy_l, x_l, xa_l, ws_l, wd_l;
    logic rdy_i, x_i, xa_i, ws_i, wd_i;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fsm_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_m), .x(x_m), .x_active(xa_m), .word_start(ws_m), .word_done(wd_m)
    );

    fsm_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_l), .x(x_l), .x_active(xa_l), .word_start(ws_l), .word_done(wd_l)
    );

    fsm_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_i (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_i), .x(x_i), .x_active(xa_i), .word_start(ws_i), .word_done(wd_i)
    );

    wire [4:0] obs_m = {x_m, xa_m, ws_m, wd_m, rdy_m};
    wire [4:0] obs_l = {x_l, xa_l, ws_l, wd_l, rdy_l};
    wire [4:0] obs_i = {x_i, xa_i, ws_i, wd_i, rdy_i};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] bp_data(input int k);
        return 8'(k * 37 + 5);
    endfunction

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if (obs_m !== 5'b00000) begin
                bad++;
                $display("FAIL reset_m k=%0d got=%b exp=%b", k, obs_m, 5'b00000);
            end
            total++;
            if (obs_i !== 5'b10000) begin
                bad++;
                $display("FAIL reset_idle k=%0d got=%b exp=%b", k, obs_i, 5'b10000);
            end
        end
        reset = 1'b0;
        #1;
        total++;
        if (obs_m !== 5'b00001) begin
            bad++;
            $display("FAIL reset_release got=%b exp=%b", obs_m, 5'b00001);
        end
        total++;
        if (obs_i !== 5'b10001) begin
            bad++;
            $display("FAIL reset_release_idle got=%b exp=%b", obs_i, 5'b10001);
        end
    endtask

    task automatic test_idle_level();
        tick();
        for (int k = 0; k < 10; k++) begin
            total++;
            if (obs_i !== 5'b10001) begin
                bad++;
                $display("FAIL idle_level k=%0d got=%b exp=%b", k, obs_i, 5'b10001);
            end
            total++;
            if (obs_m !== 5'b00001) begin
                bad++;
                $display("FAIL idle_level_m k=%0d got=%b exp=%b", k, obs_m, 5'b00001);
            end
            tick();
        end
    endtask

    task automatic test_single_word();
        logic [7:0] w;
        logic [4:0] exp;
        w = 8'hA5;
        tick();
        for (int k = 0; k <= 10; k++) begin
            in_valid = (k == 0);
            in_data  = w;
            if (k >= 2 && k <= 9) exp = {w[9-k], 1'b1, k == 2, k == 9, 1'b1};
            else                  exp = {1'b0, 1'b0, 1'b0, 1'b0, k != 1};
            total++;
            if (obs_m !== exp) begin
                bad++;
                $display("FAIL single_word k=%0d got=%b exp=%b", k, obs_m, exp);
            end
            tick();
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] w;
        logic [4:0] exp_l;
        logic [4:0] exp_m;
        w = 8'h01;
        tick();
        for (int k = 0; k <= 10; k++) begin
            in_valid = (k == 0);
            in_data  = w;
            if (k >= 2 && k <= 9) begin
                exp_l = {w[k-2], 1'b1, k == 2, k == 9, 1'b1};
                exp_m = {w[9-k], 1'b1, k == 2, k == 9, 1'b1};
            end else begin
                exp_l = {4'b0000, k != 1};
                exp_m = {4'b0000, k != 1};
            end
            total++;
            if (obs_l !== exp_l) begin
                bad++;
                $display("FAIL lsb_first k=%0d got=%b exp=%b", k, obs_l, exp_l);
            end
            total++;
            if (obs_m !== exp_m) begin
                bad++;
                $display("FAIL lsb_msb_ref k=%0d got=%b exp=%b", k, obs_m, exp_m);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp;
        tick();
        for (int k = 0; k <= 18; k++) begin
            in_valid = (k <= 2);
            in_data  = (k == 0) ? 8'hFF : 8'h00;
            exp = {k >= 2 && k <= 9, k >= 2 && k <= 17, k == 2 || k == 10,
                   k == 9 || k == 17, k == 0 || k == 2 || k >= 10};
            total++;
            if (obs_m !== exp) begin
                bad++;
                $display("FAIL back_to_back k=%0d got=%b exp=%b", k, obs_m, exp);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] w;
        logic [4:0] exp;
        w = 8'hA5;
        tick();
        for (int k = 0; k <= 5; k++) begin
            in_valid = (k <= 2);
            in_data  = (k == 0) ? w : 8'h3C;
            if (k >= 2) exp = {w[9-k], 1'b1, k == 2, 1'b0, k == 2};
            else        exp = {4'b0000, k == 0};
            total++;
            if (obs_m !== exp) begin
                bad++;
                $display("FAIL rst_mid_pre k=%0d got=%b exp=%b", k, obs_m, exp);
            end
            if (k < 5) tick();
        end
        // bit 3 of A5 (MSB first) is 0, so the IDLE_BIT=1 copy shows the async return
        total++;
        if (obs_i !== 5'b01000) begin
            bad++;
            $display("FAIL rst_mid_bit3_idle got=%b exp=%b", obs_i, 5'b01000);
        end
        reset = 1'b1;
        #1;
        total++;
        if (obs_m !== 5'b00000) begin
            bad++;
            $display("FAIL rst_mid_async got=%b exp=%b", obs_m, 5'b00000);
        end
        total++;
        if (obs_i !== 5'b10000) begin
            bad++;
            $display("FAIL rst_mid_async_idle got=%b exp=%b", obs_i, 5'b10000);
        end
        tick();
        reset = 1'b0;
        #1;
        total++;
        if (obs_m !== 5'b00001) begin
            bad++;
            $display("FAIL rst_mid_release got=%b exp=%b", obs_m, 5'b00001);
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            total++;
            if (obs_m !== 5'b00001) begin
                bad++;
                $display("FAIL rst_mid_residual k=%0d got=%b exp=%b", k, obs_m, 5'b00001);
            end
            total++;
            if (obs_i !== 5'b10001) begin
                bad++;
                $display("FAIL rst_mid_residual_idle k=%0d got=%b exp=%b", k, obs_i, 5'b10001);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] words [4];
        logic [7:0] w;
        logic [4:0] exp;
        int         idx;
        int         pos;
        // with in_valid every cycle, acceptances land in cycles 0, 2, 10 and 18
        words[0] = bp_data(0);
        words[1] = bp_data(2);
        words[2] = bp_data(10);
        words[3] = bp_data(18);
        tick();
        for (int k = 0; k <= 34; k++) begin
            in_valid = (k <= 19);
            in_data  = bp_data(k);
            if (k >= 2 && k <= 33) begin
                idx = (k - 2) / 8;
                pos = (k - 2) % 8;
                w   = words[idx];
                exp = {w[7-pos], 1'b1, pos == 0, pos == 7, 1'b0};
            end else begin
                exp = 5'b00000;
            end
            exp[0] = (k == 0 || k == 2 || k == 10 || k == 18 || k >= 26);
            total++;
            if (obs_m !== exp) begin
                bad++;
                $display("FAIL backpressure k=%0d got=%b exp=%b", k, obs_m, exp);
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_level();
        test_single_word();
        test_lsb_first();
        test_back_to_back();
        test_reset_mid_word();
        test_backpressure();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fsm_bit_serializer.md
# fsm_bit_serializer

Parallel-to-serial front end for the small Mealy FSMs in this benchmark family. Accepts WIDTH-bit words over a valid/ready handshake, buffers one word, and drives them one bit per clock onto the FSM's serial input `x`. Back-to-back words stream with no idle cycle between them. Between words, `x` carries a fixed idle level.

## Interface
- WIDTH, 8, word width in bits; legal range ≥ 2
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first
- IDLE_BIT, 1'b0, level driven on `x` when no word is being sent
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- in_data  input  WIDTH  word to serialize
- in_valid  input  1  `in_data` is valid
- in_ready  output  1  block can accept a word this cycle
- x  output  1  serial bit to the downstream FSM; registered
- x_active  output  1  `x` carries a data bit this cycle
- word_start  output  1  `x` carries the first bit of a word
- word_done  output  1  `x` carries the last bit of a word

## Operation
- **Handshake:** a word is accepted on a rising edge where `in_valid && in_ready`. `in_ready = !hold_valid`, and is forced 0 while `reset` is high.
- **Hold buffer:** an accepted word goes into `hold`, and `hold_valid` is set.
- **Shifter states:** SER_IDLE and SER_SHIFT. It holds shift register `shreg` (WIDTH bits) and bit counter `cnt` (width $clog2(WIDTH)).
- **SER_IDLE:**
  - If `hold_valid`: load `shreg <= hold`, `cnt <= 0`, clear `hold_valid`, go to SER_SHIFT.
  - Else: stay.
- **SER_SHIFT:** each cycle shift `shreg` toward the output end and increment `cnt`.
- **Last bit (`cnt == WIDTH-1`):**
  - If `hold_valid`: reload from `hold`, `cnt <= 0`, stay in SER_SHIFT (gapless).
  - Else: go to SER_IDLE.
- **Output bit:** `x` = `shreg[WIDTH-1]` if MSB_FIRST, else `shreg[0]`.
- **Status outputs:**
  - `x_active` = 1 in SER_SHIFT; in SER_IDLE, `x` = IDLE_BIT.
  - `word_start` = SER_SHIFT && `cnt == 0`.
  - `word_done` = SER_SHIFT && `cnt == WIDTH-1`.
- **Simultaneous events:** an acceptance in the same cycle the shifter empties `hold` is impossible, because `in_ready` is 0 whenever `hold_valid` is 1. A refill therefore lands one cycle after the load.
- **Bit ordering:** no reordering within a word; words are sent in acceptance order.
- **Reset values:**
  - state = SER_IDLE, `hold_valid` = 0, `cnt` = 0, `shreg` = 0.
  - `x` = IDLE_BIT, `x_active` = `word_start` = `word_done` = 0.
- **Reset mid-word:** the word in flight and any held word are discarded. `x` returns to IDLE_BIT asynchronously. No partial word resumes after reset.

## Timing
- **Latency:** word accepted at edge E0 → first bit on `x` in the cycle after edge E1. That is two edges from acceptance to the first bit.
- **Throughput:** one bit per clock sustained. `in_ready` is 1 for at least one cycle per word, since WIDTH ≥ 2 leaves time to refill `hold`.
- **`in_ready` pattern:** with `in_valid` held high, `in_ready` is high 1 cycle out of every WIDTH cycles in steady state.
- **Output timing:** `x`, `x_active`, `word_start` and `word_done` all change only on `clk` edges or async reset. They are glitch-free for the downstream FSM.
- **After reset deasserts:** first acceptance is possible in the cycle after deassertion.

## Structure
- **Shared package `fsm_pkg`:**
  - enum `ser_state_t` {SER_IDLE, SER_SHIFT}.
  - constant `SER_IDLE_BIT_DEFAULT` = 1'b0, shared with the FSMs' documented idle input.
- **Sub-module `ser_hold_buf`:** the one-entry hold register, with ports for data, valid, load-accept and take-pop. Keeps the handshake logic separate from the shifter.
- **Top-level checks:** elaboration-time assertion WIDTH ≥ 2.

## Test plan
All scenarios use WIDTH=8; MSB_FIRST=1 and IDLE_BIT=0 unless stated.
- **Single word:** `8'hA5` accepted at cycle 0 →
  - `x` = 1,0,1,0,0,1,0,1 in cycles 2–9.
  - `word_start` in cycle 2, `word_done` in cycle 9.
  - `x` = 0 and `x_active` = 0 in cycle 10.
  - `in_ready` low in cycle 1 only.
- **Back-to-back:** `8'hFF` then `8'h00`, `in_valid` held high →
  - 16 contiguous data bits, `x_active` never drops.
  - `x` shows eight 1s then eight 0s.
  - `word_done` and `word_start` fall in adjacent cycles.
- **LSB first:** MSB_FIRST=0, word `8'h01` → `x` = 1,0,0,0,0,0,0,0.
- **Idle level:** IDLE_BIT=1 with no input → `x` = 1 and `x_active` = 0 indefinitely, including immediately after reset.
- **Reset mid-word:** `8'hA5` accepted and a second word held; assert `reset` during bit 3 →
  - `x` = IDLE_BIT immediately.
  - After release, no residual bits appear.
  - `in_ready` = 1 in the first cycle after deassertion.
- **Backpressure:** `in_valid` pulsed every cycle with new data → only words accepted while `in_ready` = 1 appear on `x`, in order; none are duplicated or dropped.
